div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits.
REQ-002 Parameter: TMO, 63, max divider wait cycles before timeout (range 1..255).
REQ-003 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  in  1  synchronous active-low reset, sampled on rising clk edge.
REQ-005 Port: req  in  4  per-requester request, held high until that requester's ack.
REQ-006 Port: opa  in  4*WIDTH  dividends, requester i on bits [i*WIDTH +: WIDTH].
REQ-007 Port: opb  in  4*WIDTH  divisors, same packing as opa.
REQ-008 Port: ack  out  4  one-hot, one-cycle result-valid pulse per requester.
REQ-009 Port: res_q  out  WIDTH  quotient, valid while any ack bit high.
REQ-010 Port: res_r  out  WIDTH  remainder, valid while any ack bit high.
REQ-011 Port: res_err  out  1  error flag (divide-by-zero, divider error or timeout), valid with ack.
REQ-012 Port: res_tmo  out  1  timeout flag, valid with ack.
REQ-013 Port: busy  out  1  high in every state except IDLE.
REQ-014 Port: div_start  out  1  one-cycle start pulse to divider.
REQ-015 Port: div_a  out  WIDTH  dividend to divider, stable from ISSUE until RESP.
REQ-016 Port: div_b  out  WIDTH  divisor to divider, stable from ISSUE until RESP.
REQ-017 Port: div_done  in  1  divider completion, result valid in the same cycle.
REQ-018 Port: div_q  in  WIDTH  divider quotient.
REQ-019 Port: div_r  in  WIDTH  divider remainder.
REQ-020 Port: div_err  in  1  divider zero/overflow indication, sampled with div_done.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-022 IDLE: if req!=0, grant round-robin, searching upward from (last+1) mod 4; latch grant id, opa/opb slice into div_a/div_b; then go ISSUE if divisor!=0, else go RESP with q=0, r=0, err=1, tmo=0.
REQ-023 IDLE with req==0: stay, no outputs asserted.
REQ-024 ISSUE: div_start=1 for exactly one cycle; clear timeout counter; go WAIT.
REQ-025 WAIT: on div_done, latch div_q, div_r, err=div_err, tmo=0; go RESP.
REQ-026 WAIT: counter increments each cycle without div_done; when counter reaches TMO with no div_done, go RESP with q=0, r=0, err=1, tmo=1.
REQ-027 div_done outside WAIT SHALL be ignored.
REQ-028 RESP: ack[grant]=1 for one cycle with res_* driven; last<=grant; go IDLE.
REQ-029 res_q/res_r/res_err/res_tmo SHALL be 0 whenever ack==0.
REQ-030 Latency: req sampled in IDLE cycle t -> div_start at t+1; div_done at t+k -> ack at t+k+1; divide-by-zero -> ack at t+1.
REQ-031 Operands SHALL be captured only at grant; later opa/opb changes do not affect the operation in flight.
REQ-032 Requester dropping req mid-operation: operation completes, ack still pulses.
REQ-033 Same requester held high continuously: re-granted only when no other requester is pending (fairness, no starvation; max wait 3 operations).
REQ-034 Back-to-back: minimum one IDLE cycle between RESP and next ISSUE.

Reset
REQ-035 rst==0 at clock edge: state<=IDLE, last<=3 (so requester 0 wins first), counter<=0, all outputs 0, div_a/div_b<=0.
REQ-036 Reset mid-operation SHALL abort without ack; divider is not notified; a div_done arriving afterwards is ignored.

Verification
REQ-037 req=0001, opa0=100, opb0=7, divider done 10 cycles after start with q=14, r=2 -> ack=0001 one cycle after div_done, res_q=14, res_r=2, res_err=0.
REQ-038 req=1111 held, divider fixed latency -> grant order 0,1,2,3,0; exactly one ack bit per operation.
REQ-039 req=0100, opb2=0 -> no div_start; ack=0100 next cycle, res_err=1, res_tmo=0, res_q=0.
REQ-040 req=0010, div_done never asserted, TMO=63 -> ack=0010 with res_err=1, res_tmo=1, 63 cycles after WAIT entry.
REQ-041 rst=0 during WAIT, then div_done pulse -> no ack; busy=0; next req=1000 granted normally.
REQ-042 div_err=1 with div_done -> ack with res_err=1, res_tmo=0.

Source files
------------

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one external divider among four
// requesters. Grants in IDLE, pulses div_start in ISSUE, waits for div_done
// (with timeout) in WAIT, and returns a one-cycle ack with results in RESP.
// Every output is a register; next values are built in a single comb block.
module div_arbiter #(
    parameter int WIDTH = 8,
    parameter int TMO   = 63
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   opa,
    input  logic [4*WIDTH-1:0]   opb,
    output logic [3:0]           ack,
    output logic [WIDTH-1:0]     res_q,
    output logic [WIDTH-1:0]     res_r,
    output logic                 res_err,
    output logic                 res_tmo,
    output logic                 busy,
    output logic                 div_start,
    output logic [WIDTH-1:0]     div_a,
    output logic [WIDTH-1:0]     div_b,
    input  logic                 div_done,
    input  logic [WIDTH-1:0]     div_q,
    input  logic [WIDTH-1:0]     div_r,
    input  logic                 div_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, stateNxt;
    logic [1:0]       last, lastNxt, grant, grantNxt;
    logic [7:0]       cnt, cntNxt;
    logic [1:0]       rrPick, rrIdx;
    logic             rrHit;
    logic [3:0]       ackNxt;
    logic [WIDTH-1:0] qNxt, rNxt, aNxt, bNxt;
    logic             errNxt, tmoNxt, startNxt, busyNxt;

    // Round-robin pick: first requester found searching upward from last+1.
    // Loop runs from the farthest offset down so the nearest hit wins.
    always_comb begin
        rrPick = last;
        rrHit  = 1'b0;
        rrIdx  = last;
        for (int k = 4; k >= 1; k--) begin
            rrIdx = last + 2'(k);
            if (req[rrIdx]) begin
                rrPick = rrIdx;
                rrHit  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; outputs default to idle/zero.
    always_comb begin
        stateNxt = state;
        lastNxt  = last;
        grantNxt = grant;
        cntNxt   = cnt;
        ackNxt   = '0;
        qNxt     = '0;
        rNxt     = '0;
        errNxt   = 1'b0;
        tmoNxt   = 1'b0;
        startNxt = 1'b0;
        aNxt     = div_a;
        bNxt     = div_b;
        case (state)
            IDLE: begin
                if (rrHit) begin
                    grantNxt = rrPick;
                    aNxt     = opa[int'(rrPick)*WIDTH +: WIDTH];
                    bNxt     = opb[int'(rrPick)*WIDTH +: WIDTH];
                    if (bNxt != '0) begin
                        stateNxt = ISSUE;
                        startNxt = 1'b1;
                    end else begin
                        // Divide-by-zero never reaches the divider.
                        stateNxt = RESP;
                        ackNxt   = 4'b0001 << rrPick;
                        errNxt   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cntNxt   = '0;
                stateNxt = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    stateNxt = RESP;
                    ackNxt   = 4'b0001 << grant;
                    qNxt     = div_q;
                    rNxt     = div_r;
                    errNxt   = div_err;
                end else if (cnt == 8'(TMO - 1)) begin
                    // TMO-th WAIT cycle without completion: give up.
                    stateNxt = RESP;
                    ackNxt   = 4'b0001 << grant;
                    errNxt   = 1'b1;
                    tmoNxt   = 1'b1;
                end else begin
                    cntNxt = cnt + 8'd1;
                end
            end
            RESP: begin
                lastNxt  = grant;
                stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
        busyNxt = (stateNxt != IDLE);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= 2'd3;
            grant     <= 2'd0;
            cnt       <= '0;
            ack       <= '0;
            res_q     <= '0;
            res_r     <= '0;
            res_err   <= 1'b0;
            res_tmo   <= 1'b0;
            busy      <= 1'b0;
            div_start <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
        end else begin
            state     <= stateNxt;
            last      <= lastNxt;
            grant     <= grantNxt;
            cnt       <= cntNxt;
            ack       <= ackNxt;
            res_q     <= qNxt;
            res_r     <= rNxt;
            res_err   <= errNxt;
            res_tmo   <= tmoNxt;
            busy      <= busyNxt;
            div_start <= startNxt;
            div_a     <= aNxt;
            div_b     <= bNxt;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider, scoreboard of expected acks,
// one task per scenario.
module tb_div_arbiter;
    localparam int WIDTH = 8;
    localparam int TMO   = 63;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [3:0]         req = '0;
    logic [4*WIDTH-1:0] opa = '0;
    logic [4*WIDTH-1:0] opb = '0;
    logic [3:0]         ack;
    logic [WIDTH-1:0]   res_q, res_r;
    logic               res_err, res_tmo, busy, div_start;
    logic [WIDTH-1:0]   div_a, div_b;
    logic               div_done = 1'b0;
    logic [WIDTH-1:0]   div_q = '0;
    logic [WIDTH-1:0]   div_r = '0;
    logic               div_err = 1'b0;

    div_arbiter #(.WIDTH(WIDTH), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
        .ack(ack), .res_q(res_q), .res_r(res_r), .res_err(res_err),
        .res_tmo(res_tmo), .busy(busy), .div_start(div_start),
        .div_a(div_a), .div_b(div_b), .div_done(div_done),
        .div_q(div_q), .div_r(div_r), .div_err(div_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [3:0]       ack;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             err;
        logic             tmo;
    } exp_t;
    exp_t sb[$];
    exp_t monE;

    // Divider model: answers div_start after divLat cycles using the
    // operands the DUT is presenting at completion time.
    bit               divRespond = 1'b1;
    bit               divErrMode = 1'b0;
    bit               divActive  = 1'b0;
    int               divLat     = 4;
    int               startCount = 0;
    int               startCyc   = 0;
    int               doneCyc    = 0;
    logic [WIDTH-1:0] mA, mB;

    initial forever begin
        @(negedge clk);
        if (div_start === 1'b1) begin
            startCount++;
            startCyc = cyc;
            if (divRespond) begin
                divActive = 1'b1;
                repeat (divLat) @(negedge clk);
                mA = div_a;
                mB = div_b;
                div_done = 1'b1;
                div_q    = (mB != 0) ? mA / mB : '0;
                div_r    = (mB != 0) ? mA % mB : '0;
                div_err  = divErrMode;
                doneCyc  = cyc;
                @(negedge clk);
                div_done  = 1'b0;
                div_q     = '0;
                div_r     = '0;
                div_err   = 1'b0;
                divActive = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every ack pops one expectation; outside acks the
    // result bus must be zero.
    int ackCount = 0;
    int ackCyc   = 0;
    always begin
        @(posedge clk);
        #1;
        if (ack !== 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ack ack=%b with empty scoreboard", ack);
            end else begin
                monE = sb.pop_front();
                if (ack !== monE.ack || res_q !== monE.q || res_r !== monE.r ||
                    res_err !== monE.err || res_tmo !== monE.tmo) begin
                    fails++;
                    $display("FAIL ack_result got ack=%b q=%0d r=%0d err=%b tmo=%b want ack=%b q=%0d r=%0d err=%b tmo=%b",
                             ack, res_q, res_r, res_err, res_tmo,
                             monE.ack, monE.q, monE.r, monE.err, monE.tmo);
                end
            end
            ackCount++;
            ackCyc = cyc;
        end else begin
            checks++;
            if ({res_q, res_r, res_err, res_tmo} !== '0) begin
                fails++;
                $display("FAIL idle_result got q=%0d r=%0d err=%b tmo=%b want all 0",
                         res_q, res_r, res_err, res_tmo);
            end
        end
    end

    task automatic wait_acks(input int target, input int budget, output bit ok);
        int n = 0;
        while (ackCount < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (ackCount >= target);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, busy, div_start, div_a, div_b} !== '0) begin
            fails++;
            $display("FAIL reset_state got ack=%b busy=%b start=%b a=%0d b=%0d want 0",
                     ack, busy, div_start, div_a, div_b);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        bit ok;
        int base = ackCount;
        int lane;
        logic [WIDTH-1:0] a, b;
        divLat = 3;
        opa = {8'd90, 8'd60, 8'd45, 8'd20};
        opb = {8'd9,  8'd7,  8'd4,  8'd3};
        for (int k = 0; k < 5; k++) begin
            lane = k % 4;
            a = opa[lane*WIDTH +: WIDTH];
            b = opb[lane*WIDTH +: WIDTH];
            sb.push_back('{4'b0001 << lane, a / b, a % b, 1'b0, 1'b0});
        end
        req = 4'b1111;
        wait_acks(base + 5, 200, ok);
        req = '0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL rr_timeout got %0d acks want 5", ackCount - base);
        end
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        int base = ackCount;
        int reqCyc;
        divLat = 10;
        opa[7:0] = 8'd100;
        opb[7:0] = 8'd7;
        sb.push_back('{4'b0001, 8'd14, 8'd2, 1'b0, 1'b0});
        req = 4'b0001;
        reqCyc = cyc;
        @(negedge clk);
        checks++;
        if (div_start !== 1'b1 || div_a !== 8'd100 || div_b !== 8'd7 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_issue got start=%b a=%0d b=%0d busy=%b want 1 100 7 1",
                     div_start, div_a, div_b, busy);
        end
        // Operands changing after grant must not reach the divider.
        opa[7:0] = 8'd200;
        opb[7:0] = 8'd3;
        wait_acks(base + 1, 40, ok);
        req = '0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL basic_timeout got no ack want ack");
        end
        checks++;
        if (startCyc !== reqCyc + 1) begin
            fails++;
            $display("FAIL basic_start_latency got %0d want %0d", startCyc - reqCyc, 1);
        end
        checks++;
        if (ackCyc !== doneCyc + 1) begin
            fails++;
            $display("FAIL basic_ack_latency got %0d want %0d", ackCyc - doneCyc, 1);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_div_zero;
        bit ok;
        int base = ackCount;
        int sc = startCount;
        int reqCyc;
        opa[23:16] = 8'd55;
        opb[23:16] = 8'd0;
        sb.push_back('{4'b0100, 8'd0, 8'd0, 1'b1, 1'b0});
        req = 4'b0100;
        reqCyc = cyc;
        wait_acks(base + 1, 20, ok);
        req = '0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL dz_timeout got no ack want ack");
        end
        checks++;
        if (startCount !== sc) begin
            fails++;
            $display("FAIL dz_no_start got %0d starts want 0", startCount - sc);
        end
        checks++;
        if (ackCyc !== reqCyc + 1) begin
            fails++;
            $display("FAIL dz_latency got %0d want 1", ackCyc - reqCyc);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        bit ok;
        int base = ackCount;
        divRespond = 1'b0;
        opa[15:8] = 8'd77;
        opb[15:8] = 8'd5;
        sb.push_back('{4'b0010, 8'd0, 8'd0, 1'b1, 1'b1});
        req = 4'b0010;
        wait_acks(base + 1, 200, ok);
        req = '0;
        divRespond = 1'b1;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL tmo_no_ack got no ack want ack");
        end
        // WAIT is entered the cycle after start; ack lands TMO cycles later.
        checks++;
        if (ackCyc !== startCyc + 1 + TMO) begin
            fails++;
            $display("FAIL tmo_latency got %0d want %0d", ackCyc - startCyc - 1, TMO);
        end
        @(negedge clk);
    endtask

    task automatic test_div_err;
        bit ok;
        int base = ackCount;
        divLat = 5;
        divErrMode = 1'b1;
        opa[31:24] = 8'd50;
        opb[31:24] = 8'd6;
        sb.push_back('{4'b1000, 8'd8, 8'd2, 1'b1, 1'b0});
        req = 4'b1000;
        wait_acks(base + 1, 40, ok);
        req = '0;
        divErrMode = 1'b0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL derr_no_ack got no ack want ack");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int base;
        int sc = startCount;
        int n = 0;
        divLat = 8;
        opa[7:0] = 8'd30;
        opb[7:0] = 8'd4;
        req = 4'b0001;
        while (startCount == sc && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (startCount == sc) begin
            fails++;
            $display("FAIL rm_no_start got 0 starts want 1");
        end
        repeat (2) @(negedge clk);
        base = ackCount;
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (divActive && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ackCount !== base) begin
            fails++;
            $display("FAIL rm_spurious_ack got %0d acks want 0", ackCount - base);
        end
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rm_busy got %b want 0", busy);
        end
        divLat = 2;
        opa[31:24] = 8'd99;
        opb[31:24] = 8'd10;
        sb.push_back('{4'b1000, 8'd9, 8'd9, 1'b0, 1'b0});
        req = 4'b1000;
        wait_acks(base + 1, 30, ok);
        req = '0;
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL rm_next_no_ack got no ack want ack");
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_div_zero();
        test_timeout();
        test_div_err();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before test end");
        $fatal(1);
    end

endmodule
